// File: rtl/tex_char_serializer_if.sv
// Handshake bundle for the character-pair serializer: pair input from the
// transformer stage and the byte stream towards the output/UART path.
interface tex_char_serializer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_lhs;
  logic [7:0] in_rhs;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  // Producer of pairs and consumer of bytes (the environment around the serializer).
  modport master (
    output in_valid, in_lhs, in_rhs, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // The serializer itself.
  modport slave (
    input  in_valid, in_lhs, in_rhs, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/tex_char_serializer.sv
// Buffers {lhs, rhs, last} character pairs in a small FIFO and serializes each
// entry into lhs, rhs and an optional end-of-line byte on a valid/ready stream.
module tex_char_serializer #(
  parameter int unsigned DEPTH      = 4,
  parameter bit          SKIP_SPACE = 1'b1,
  parameter logic [7:0]  EOL_CHAR   = 8'h0A
) (
  input  logic                        clk,
  input  logic                        rst_n,
  tex_char_serializer_if.slave        bus,
  output logic                        busy,
  output logic [7:0]                  byte_count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [7:0]  SPACE = 8'h20;

  typedef enum logic [1:0] {
    PH_L = 2'd0,
    PH_R = 2'd1,
    PH_E = 2'd2
  } phase_e;

  typedef struct packed {
    logic       last;
    logic [7:0] lhs;
    logic [7:0] rhs;
  } entry_t;

  // Padding spaces are dropped only when suppression is enabled.
  function automatic logic is_skipped(input logic [7:0] c);
    return SKIP_SPACE && (c == SPACE);
  endfunction

  entry_t      mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  phase_e      phase_q, phase_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic [7:0]  out_data_q, out_data_d;
  logic [7:0]  byte_count_q, byte_count_d;

  logic        full_s;
  logic        empty_s;
  logic        push_s;
  logic        pop_s;
  logic        slot_free_s;
  entry_t      head_s;
  entry_t      wr_entry_s;

  // The wrap bit distinguishes full from empty when the index bits match.
  assign full_s      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_s     = (wr_ptr_q == rd_ptr_q);
  assign push_s      = bus.in_valid && !full_s;
  assign slot_free_s = !out_valid_q || bus.out_ready;
  assign head_s      = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_entry_s  = '{last: bus.in_last, lhs: bus.in_lhs, rhs: bus.in_rhs};

  // Pair storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_entry_s;
    end
  end

  // Pointer advance on push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Phase FSM: one phase per cycle, acting only with a head entry and a free slot.
  always_comb begin
    phase_d     = phase_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    pop_s       = 1'b0;
    if (slot_free_s) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      if (!empty_s) begin
        case (phase_q)
          PH_L: begin
            if (is_skipped(head_s.lhs)) begin
              out_valid_d = 1'b0;
            end else begin
              out_data_d  = head_s.lhs;
              out_valid_d = 1'b1;
            end
            phase_d = PH_R;
          end
          PH_R: begin
            if (is_skipped(head_s.rhs)) begin
              out_valid_d = 1'b0;
            end else begin
              out_data_d  = head_s.rhs;
              out_valid_d = 1'b1;
            end
            if (head_s.last) begin
              phase_d = PH_E;
            end else begin
              phase_d = PH_L;
              pop_s   = 1'b1;
            end
          end
          PH_E: begin
            out_data_d  = EOL_CHAR;
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
            pop_s       = 1'b1;
            phase_d     = PH_L;
          end
          default: begin
            phase_d = PH_L;
          end
        endcase
      end else begin
        phase_d = phase_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Accepted-byte counter, wrapping modulo 256.
  always_comb begin
    byte_count_d = byte_count_q;
    if (out_valid_q && bus.out_ready) begin
      byte_count_d = byte_count_q + 8'd1;
    end else begin
      byte_count_d = byte_count_q;
    end
  end

  // State registers; reset drops buffered pairs and any held output byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      phase_q      <= PH_L;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      out_last_q   <= 1'b0;
      byte_count_q <= 8'h00;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      phase_q      <= phase_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign bus.in_ready  = !full_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign byte_count    = byte_count_q;
  assign busy          = !empty_s || out_valid_q || (phase_q != PH_L);

endmodule

// File: tb/tb_tex_char_serializer.sv
// Self-checking bench: directed scenarios plus random traffic against a byte-queue model.
module tb_tex_char_serializer;
  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] byte_count;
  int         total;
  int         bad;
  logic [8:0] exp_q[$];

  tex_char_serializer_if bus ();

  tex_char_serializer #(
    .DEPTH(4), .SKIP_SPACE(1'b1), .EOL_CHAR(8'h0A)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected byte stream for one accepted pair: {last, data} per byte.
  function automatic void model_push(input logic [7:0] l, input logic [7:0] r, input logic last);
    if (l != 8'h20) exp_q.push_back({1'b0, l});
    if (r != 8'h20) exp_q.push_back({1'b0, r});
    if (last) exp_q.push_back({1'b1, 8'h0A});
  endfunction

  function automatic logic [7:0] rand_char(input bit allow_space);
    if (allow_space && ($urandom_range(3, 0) == 0)) return 8'h20;
    return 8'($urandom_range(32'h7E, 32'h21));
  endfunction

  task automatic apply_reset();
    bus.in_valid = 1'b0; bus.in_lhs = 8'h00; bus.in_rhs = 8'h00;
    bus.in_last = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", bus.out_last); end
    total++; if (byte_count !== 8'd0) begin bad++; $display("FAIL reset_byte_count got=%0d exp=0", byte_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_single_pair();
    logic       ev [4];
    logic [7:0] ed [4];
    logic       eb [4];
    logic [7:0] ec [4];
    ev = '{1'b0, 1'b1, 1'b1, 1'b0};
    ed = '{8'h00, 8'h31, 8'h73, 8'h00};
    eb = '{1'b1, 1'b1, 1'b1, 1'b0};
    ec = '{8'd0, 8'd0, 8'd1, 8'd2};
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_lhs = 8'h31; bus.in_rhs = 8'h73; bus.in_last = 1'b0;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== ev[i] || (ev[i] && bus.out_data !== ed[i]) || bus.out_last !== 1'b0 ||
          busy !== eb[i] || byte_count !== ec[i]) begin
        bad++;
        $display("FAIL single_pair step %0d got v=%b d=%h l=%b busy=%b bc=%0d exp v=%b d=%h l=0 busy=%b bc=%0d",
                 i, bus.out_valid, bus.out_data, bus.out_last, busy, byte_count, ev[i], ed[i], eb[i], ec[i]);
      end
    end
  endtask

  task automatic test_skip_eol();
    logic       ev [5];
    logic [7:0] ed [5];
    logic       el [5];
    logic       eb [5];
    logic [7:0] ec [5];
    ev = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ed = '{8'h00, 8'h73, 8'h00, 8'h0A, 8'h00};
    el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    eb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ec = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2};
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_lhs = 8'h73; bus.in_rhs = 8'h20; bus.in_last = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== ev[i] || (ev[i] && bus.out_data !== ed[i]) || bus.out_last !== el[i] ||
          busy !== eb[i] || byte_count !== ec[i]) begin
        bad++;
        $display("FAIL skip_eol step %0d got v=%b d=%h l=%b busy=%b bc=%0d exp v=%b d=%h l=%b busy=%b bc=%0d",
                 i, bus.out_valid, bus.out_data, bus.out_last, busy, byte_count, ev[i], ed[i], el[i], eb[i], ec[i]);
      end
    end
  endtask

  task automatic test_space_pair();
    logic       ev [5];
    logic [7:0] ed [5];
    logic       eb [5];
    logic [7:0] ec [5];
    ev = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    ed = '{8'h00, 8'h00, 8'h5E, 8'h32, 8'h00};
    eb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ec = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2};
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_lhs = 8'h20; bus.in_rhs = 8'h20; bus.in_last = 1'b0;
    @(posedge clk); #1 bus.in_lhs = 8'h5E; bus.in_rhs = 8'h32;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== ev[i] || (ev[i] && bus.out_data !== ed[i]) || bus.out_last !== 1'b0 ||
          busy !== eb[i] || byte_count !== ec[i]) begin
        bad++;
        $display("FAIL space_pair step %0d got v=%b d=%h busy=%b bc=%0d exp v=%b d=%h busy=%b bc=%0d",
                 i, bus.out_valid, bus.out_data, busy, byte_count, ev[i], ed[i], eb[i], ec[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] l [6];
    logic [7:0] r [6];
    logic [8:0] e;
    int acc;
    int got;
    acc = 0; got = 0;
    for (int i = 0; i < 6; i++) begin l[i] = rand_char(1'b0); r[i] = rand_char(1'b0); end
    apply_reset();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_lhs = l[0]; bus.in_rhs = r[0]; bus.in_last = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin model_push(l[acc], r[acc], 1'b0); acc++; end
      if (c >= 2) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== l[0]) begin
          bad++; $display("FAIL bp_hold cycle %0d got v=%b d=%h exp v=1 d=%h", c, bus.out_valid, bus.out_data, l[0]);
        end
      end
      @(posedge clk); #1;
      if (acc < 6) begin bus.in_lhs = l[acc]; bus.in_rhs = r[acc]; end
      else bus.in_valid = 1'b0;
    end
    total++; if (acc !== 4) begin bad++; $display("FAIL bp_accepts got=%0d exp=4", acc); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        got++; total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL bp_extra_byte got=%h exp=none", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_last, bus.out_data} !== e) begin
            bad++; $display("FAIL bp_order got=%h exp=%h", {bus.out_last, bus.out_data}, e);
          end
        end
      end
    end
    total++; if (got !== 8) begin bad++; $display("FAIL bp_byte_total got=%0d exp=8", got); end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] ql;
    logic [7:0] qr;
    logic       ev [4];
    logic [7:0] ed [4];
    ql = rand_char(1'b0); qr = rand_char(1'b0);
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_lhs = rand_char(1'b0); bus.in_rhs = rand_char(1'b0); bus.in_last = 1'b0;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_lhs = rand_char(1'b0); bus.in_rhs = rand_char(1'b0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || byte_count !== 8'd2) begin
      bad++; $display("FAIL rst_mid_pre got v=%b bc=%0d exp v=1 bc=2", bus.out_valid, byte_count);
    end
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (byte_count !== 8'd0) begin bad++; $display("FAIL rst_mid_byte_count got=%0d exp=0", byte_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready got=%b exp=1", bus.in_ready); end
    ev = '{1'b0, 1'b1, 1'b1, 1'b0};
    ed = '{8'h00, ql, qr, 8'h00};
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_lhs = ql; bus.in_rhs = qr; bus.in_last = 1'b0;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== ev[i] || (ev[i] && bus.out_data !== ed[i])) begin
        bad++; $display("FAIL rst_mid_after step %0d got v=%b d=%h exp v=%b d=%h",
                        i, bus.out_valid, bus.out_data, ev[i], ed[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int pushed;
    int rcv;
    bit started;
    bit acc;
    logic [8:0] e;
    pushed = 0; rcv = 0; started = 1'b0;
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_lhs = rand_char(1'b0); bus.in_rhs = rand_char(1'b0); bus.in_last = 1'b0;
    for (int c = 0; c < 600 && rcv < 260; c++) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin model_push(bus.in_lhs, bus.in_rhs, 1'b0); pushed++; end
      if (started && !bus.out_valid) begin
        total++; bad++; $display("FAIL wrap_gap at byte %0d got v=0 exp v=1", rcv);
      end
      if (bus.out_valid && bus.out_ready) begin
        started = 1'b1; rcv++; total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL wrap_extra_byte got=%h exp=none", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_last, bus.out_data} !== e) begin
            bad++; $display("FAIL wrap_order byte %0d got=%h exp=%h", rcv, {bus.out_last, bus.out_data}, e);
          end
        end
      end
      @(posedge clk); #1;
      if (pushed >= 130) bus.in_valid = 1'b0;
      else if (acc) begin bus.in_lhs = rand_char(1'b0); bus.in_rhs = rand_char(1'b0); end
    end
    total++; if (rcv !== 260) begin bad++; $display("FAIL wrap_byte_total got=%0d exp=260", rcv); end
    @(negedge clk);
    total++; if (byte_count !== 8'd4) begin bad++; $display("FAIL wrap_byte_count got=%0d exp=4", byte_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_busy got=%b exp=0", busy); end
  endtask

  task automatic test_random();
    int bc;
    logic [8:0] e;
    bc = 0;
    apply_reset();
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      total++;
      if (byte_count !== 8'(bc)) begin bad++; $display("FAIL rnd_byte_count cycle %0d got=%0d exp=%0d", c, byte_count, bc % 256); end
      if (bus.in_valid && bus.in_ready) model_push(bus.in_lhs, bus.in_rhs, bus.in_last);
      if (bus.out_valid && bus.out_ready) begin
        bc++; total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rnd_extra_byte got=%h exp=none", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_last, bus.out_data} !== e) begin
            bad++; $display("FAIL rnd_order cycle %0d got=%h exp=%h", c, {bus.out_last, bus.out_data}, e);
          end
        end
      end
      @(posedge clk); #1;
      if (c < 600) begin
        bus.in_valid  = ($urandom_range(9, 0) < 6);
        bus.in_lhs    = rand_char(1'b1);
        bus.in_rhs    = rand_char(1'b1);
        bus.in_last   = ($urandom_range(3, 0) == 0);
        bus.out_ready = ($urandom_range(9, 0) < 7);
      end else begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_missing_bytes got=%0d exp=0", exp_q.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_busy_idle got=%b exp=0", busy); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    test_reset();
    test_single_pair();
    test_skip_eol();
    test_space_pair();
    test_backpressure();
    test_reset_midstream();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tex_char_serializer.md
Name: tex_char_serializer

Overview:
- Sits directly downstream of the transformer stage.
- Accepts one {lhs, rhs} ASCII character pair per handshake and buffers the pairs in a small FIFO.
- Serializes each pair into a byte stream on a valid/ready output: lhs, then rhs, then an optional end-of-line byte.
- Space-padding bytes (0x20), which fill unused memory words, are suppressed when SKIP_SPACE=1. The output feeds the chip's 8-bit output/UART path.

Parameters:
DEPTH, 4, FIFO depth in pair entries; power of two, >=2
SKIP_SPACE, 1, 1 = drop 0x20 bytes from lhs/rhs; 0 = emit all bytes
EOL_CHAR, 8'h0A, byte emitted after an entry tagged last

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  pair presented
in_ready  out  1  FIFO can accept; equals !full
in_lhs  in  8  input-side character (transformer lhs)
in_rhs  in  8  transformed character (transformer rhs)
in_last  in  1  pair is last of a line; appends EOL_CHAR
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts byte
out_data  out  8  serialized byte
out_last  out  1  high with the EOL_CHAR byte only
busy  out  1  FIFO non-empty OR out_valid OR phase != PH_L
byte_count  out  8  bytes accepted (out_valid&out_ready); wraps 255->0

Behaviour:
- Reset (rst_n=0 at an edge):
  - out_valid=0, out_data=0, out_last=0, byte_count=0.
  - FIFO emptied; phase=PH_L; in_ready=1 on the following cycle.
  - Reset mid-stream discards all buffered pairs and any held output byte; nothing is re-emitted.
- FIFO storage: entries are {last, lhs, rhs}, 17 bits each.
  - Push on in_valid&in_ready.
  - No bypass: when full, in_ready=0 even if a pop occurs that cycle.
  - Pointers are log2(DEPTH) bits wide plus a wrap bit, so full and empty are distinct states.
- Slot free = !out_valid | out_ready. The output register is updated only when the slot is free.
  - While out_valid&!out_ready, out_data and out_last hold stable.
  - If the slot is free and nothing is loaded that cycle, out_valid goes to 0 at the next edge.
- Phase FSM (per head entry). It acts only when the FIFO is non-empty and the slot is free; otherwise it holds.
  - PH_L: if SKIP_SPACE and lhs==0x20, skip (out_valid->0). Else load out_data=lhs, out_valid=1. Next phase: PH_R.
  - PH_R: rhs is skipped or loaded by the same rule.
    - If head.last=1, go to PH_E.
    - Otherwise pop the head and go to PH_L.
  - PH_E: load out_data=EOL_CHAR, out_last=1, out_valid=1; pop the head; go to PH_L. EOL_CHAR is never skipped.
- Each phase costs exactly one cycle, including skipped phases.
  - A {0x20,0x20} non-last entry takes 2 cycles and produces no output.
- Latency from an idle, empty state: lhs appears on out_data with out_valid=1 one cycle after the accepting edge. Sustained throughput is one byte per cycle.
- Simultaneous push and pop in the same cycle is legal when not full; the count is unchanged.
- Byte ordering is strictly FIFO order, lhs before rhs before EOL.
- byte_count increments only on out_valid&out_ready. It is 8 bits and wraps modulo 256.

Test Plan:
1. Single pair {0x31,0x73}, last=0, out_ready=1 held high:
   - out_data 0x31 then 0x73 on consecutive cycles; out_last=0 throughout.
   - byte_count=2; busy falls one cycle after the 0x73 byte.
2. SKIP_SPACE=1, pair {0x73,0x20}, last=1:
   - Outputs 0x73, then a one-cycle out_valid=0 gap, then 0x0A with out_last=1.
   - byte_count=2.
3. Pairs {0x20,0x20} last=0, then {0x5E,0x32} last=0:
   - No byte is emitted for the first pair.
   - 0x5E appears 2 cycles after the first pair's lhs phase, followed by 0x32.
4. Backpressure, out_ready=0, offer 6 pairs back to back:
   - in_ready drops after 4 accepts; out_data holds the first lhs stable.
   - After out_ready=1, all 8 bytes are emitted in order with no loss or duplication.
5. Reset asserted while out_valid=1 with 3 entries buffered:
   - Next cycle: out_valid=0, byte_count=0, busy=0, in_ready=1.
   - A new pair afterwards emits normally.
6. Stream 130 non-space pairs with out_ready=1:
   - byte_count wraps to 4 (260 mod 256).
   - No gaps between bytes once the FIFO is primed.
